// File: rtl/pwm_bank.sv
// +----------------------------------------------------------------------------+
// | pwm_bank : N-channel PWM generator, shared period, edge/centre alignment,  |
// |            double-buffered duty/period/mode.            Revision: 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_bank #(
   parameter int NUM_CH = 8,
   parameter int DW     = 16,
   parameter int AW     = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [AW-1:0]     addr,
   input  logic [15:0]       wr_data,
   output logic [15:0]       rd_data,
   output logic [NUM_CH-1:0] pwm,
   output logic              period_end
);

   localparam logic [AW-1:0] C_A_PERIOD = AW'(NUM_CH);
   localparam logic [AW-1:0] C_A_CTRL   = AW'(NUM_CH + 1);
   localparam logic [AW-1:0] C_A_MASK   = AW'(NUM_CH + 2);

   logic [DW-1:0]     r_period_sh;
   logic [DW-1:0]     r_period_act;
   logic [1:0]        r_ctrl;
   logic              r_mode_act;
   logic [NUM_CH-1:0] r_mask;
   logic [DW-1:0]     r_cnt;
   logic              r_dir;
   logic [NUM_CH-1:0] r_pwm;
   logic [15:0]       r_rd_data;

   logic [DW-1:0]     w_wdata;
   logic [DW-1:0]     w_duty_sh [NUM_CH];
   logic [NUM_CH-1:0] w_cmp;
   logic [DW-1:0]     w_period_nxt;
   logic [1:0]        w_ctrl_nxt;
   logic [NUM_CH-1:0] w_mask_nxt;
   logic              w_at_top;
   logic              w_pend_ctr;
   logic              w_pend;
   logic              w_load;
   logic [15:0]       w_rd_val;

   assign w_wdata      = wr_data[DW-1:0];
   assign w_period_nxt = (wr_en && addr == C_A_PERIOD) ? w_wdata : r_period_sh;
   assign w_ctrl_nxt   = (wr_en && addr == C_A_CTRL) ? wr_data[1:0] : r_ctrl;
   assign w_mask_nxt   = (wr_en && addr == C_A_MASK) ? wr_data[NUM_CH-1:0] : r_mask;

   assign w_at_top   = (r_cnt == r_period_act);
   // P=1 in centre mode reaches cnt==1 while still counting up; that is the period end
   assign w_pend_ctr = (r_period_act == '0) |
                       ((r_cnt == DW'(1)) & (r_dir | (r_period_act == DW'(1))));
   assign w_pend     = r_ctrl[0] & (r_mode_act ? w_pend_ctr : w_at_top);
   assign w_load     = ~r_ctrl[0] | w_pend;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DW-1:0] r_duty_sh;
      logic [DW-1:0] r_duty_act;
      logic [DW-1:0] w_duty_nxt;

      assign w_duty_nxt    = (wr_en && addr == AW'(gi)) ? w_wdata : r_duty_sh;
      assign w_duty_sh[gi] = r_duty_sh;
      // Down-count half compares inclusively so a centred pulse is 2*duty wide
      assign w_cmp[gi]     = (r_cnt < r_duty_act) | (r_dir & (r_cnt == r_duty_act));

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_duty_sh  <= '0;
            r_duty_act <= '0;
         end else begin
            r_duty_sh <= w_duty_nxt;
            if (w_load) r_duty_act <= w_duty_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_period_sh  <= '0;
         r_period_act <= '0;
         r_ctrl       <= '0;
         r_mode_act   <= 1'b0;
         r_mask       <= '0;
      end else begin
         r_period_sh <= w_period_nxt;
         r_ctrl      <= w_ctrl_nxt;
         r_mask      <= w_mask_nxt;
         if (w_load) begin
            r_period_act <= w_period_nxt;
            r_mode_act   <= w_ctrl_nxt[1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_dir <= 1'b0;
      end else if (w_load) begin
         r_cnt <= '0;
         r_dir <= 1'b0;
      end else if (!r_mode_act) begin
         r_cnt <= r_cnt + DW'(1);
      end else if (r_dir) begin
         r_cnt <= r_cnt - DW'(1);
      end else if (w_at_top) begin
         r_dir <= 1'b1;
         r_cnt <= r_cnt - DW'(1);
      end else begin
         r_cnt <= r_cnt + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_pwm <= '0;
      else        r_pwm <= r_ctrl[0] ? (r_mask & w_cmp) : '0;
   end

   always_comb begin
      w_rd_val = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (addr == AW'(i)) w_rd_val = 16'(w_duty_sh[i]);
      if (addr == C_A_PERIOD)    w_rd_val = 16'(r_period_sh);
      else if (addr == C_A_CTRL) w_rd_val = 16'(r_ctrl);
      else if (addr == C_A_MASK) w_rd_val = 16'(r_mask);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     r_rd_data <= '0;
      else if (rd_en) r_rd_data <= w_rd_val;
   end

   assign rd_data    = r_rd_data;
   assign pwm        = r_pwm;
   assign period_end = w_pend;

endmodule

`default_nettype wire

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank : directed self-checking bench for pwm_bank (8 channels, 16-bit).
`default_nettype none

module tb_pwm_bank;
   localparam int NUM_CH = 8;
   localparam int DW     = 16;
   localparam int AW     = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic              rd_en;
   logic [AW-1:0]     addr;
   logic [15:0]       wr_data;
   logic [15:0]       rd_data;
   logic [NUM_CH-1:0] pwm;
   logic              period_end;

   int n_vec = 0;
   int n_err = 0;
   int hi [NUM_CH];
   int npend;
   logic [7:0] v_pwm0, v_pwm1, v_pend;

   pwm_bank #(.NUM_CH(NUM_CH), .DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .pwm(pwm), .period_end(period_end)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      wr_en = 1'b1; addr = AW'(a); wr_data = 16'(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input int a, output logic [15:0] v);
      rd_en = 1'b1; addr = AW'(a);
      tick();
      rd_en = 1'b0;
      v = rd_data;
   endtask

   task automatic run(input int n);
      npend = 0;
      for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         for (int c = 0; c < NUM_CH; c++) if (pwm[c]) hi[c]++;
         if (period_end) npend++;
      end
   endtask

   task automatic centre8();
      for (int k = 0; k < 8; k++) begin
         tick();
         v_pwm0[k] = pwm[0];
         v_pwm1[k] = pwm[1];
         v_pend[k] = period_end;
      end
   endtask

   task automatic check_all_zero(input string tag);
      logic [15:0] v;
      for (int a = 0; a < NUM_CH + 3; a++) begin
         rd(a, v);
         chk($sformatf("%s_rd%0d", tag, a), 32'(v), 32'h0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;

      // Reset values
      repeat (3) tick();
      chk("rst_pwm", 32'(pwm), 32'h0);
      chk("rst_pend", 32'(period_end), 32'h0);
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      reset = 1'b1;
      tick();
      check_all_zero("rst");
      run(12);
      chk("rst_no_pend", npend, 0);
      chk("rst_no_pwm", hi[0] + hi[7], 0);

      // Register programming, masking, unmapped address
      wr(NUM_CH, 9);
      for (int i = 0; i < NUM_CH; i++) wr(i, i + 1);
      wr(NUM_CH + 2, 16'hFFFF);
      rd(NUM_CH + 2, v); chk("mask_rd", 32'(v), 32'h00FF);
      rd(NUM_CH, v);     chk("period_rd", 32'(v), 32'd9);
      rd(7, v);          chk("duty7_rd", 32'(v), 32'd8);
      wr(20, 16'hABCD);
      rd(20, v);         chk("unmapped_rd", 32'(v), 32'h0);

      // Edge mode, duty i+1 of period 10
      wr(NUM_CH + 1, 1);
      rd(NUM_CH + 1, v); chk("ctrl_rd", 32'(v), 32'h1);
      wr(NUM_CH + 1, 0);
      wr(NUM_CH + 1, 1);
      run(10);
      for (int i = 0; i < NUM_CH; i++) chk($sformatf("edge_hi%0d", i), hi[i], i + 1);
      chk("edge_pend1", npend, 1);
      run(20);
      chk("edge_pend2", npend, 2);
      chk("edge_hi7_20", hi[7], 16);

      // Duty extremes
      wr(NUM_CH + 1, 0);
      wr(0, 0); wr(1, 10); wr(2, 16'hFFFF);
      wr(NUM_CH + 1, 1);
      run(10);
      chk("ext_duty0", hi[0], 0);
      chk("ext_duty10", hi[1], 10);
      chk("ext_dutyFFFF", hi[2], 10);
      chk("ext_duty4", hi[3], 4);

      // Simultaneous read and write returns the old value
      wr_en = 1'b1; rd_en = 1'b1; addr = AW'(3); wr_data = 16'h0055;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("rdwr_old", 32'(rd_data), 32'd4);
      rd(3, v); chk("rdwr_new", 32'(v), 32'h55);

      // Double buffering
      wr(NUM_CH + 1, 0);
      wr(0, 3);
      wr(NUM_CH + 1, 1);
      run(5);
      chk("dbuf_first5", hi[0], 3);
      wr(0, 7);
      run(4);
      chk("dbuf_rest", hi[0], 0);
      run(10);
      chk("dbuf_next", hi[0], 7);
      chk("dbuf_pend", npend, 1);
      for (int k = 0; k < 50 && period_end !== 1'b1; k++) tick();
      chk("wait_pend", 32'(period_end), 32'h1);
      wr(0, 2);
      run(10);
      chk("dbuf_on_pend", hi[0], 2);

      // Centre mode, P=4, duty0=2
      wr(NUM_CH + 1, 0);
      wr(NUM_CH, 4);
      wr(0, 2);
      wr(NUM_CH + 1, 3);
      centre8();
      chk("ctr1_pwm0", 32'(v_pwm0), 32'hC3);
      chk("ctr1_pend", 32'(v_pend), 32'h40);
      centre8();
      chk("ctr2_pwm0", 32'(v_pwm0), 32'hC3);
      chk("ctr2_pend", 32'(v_pend), 32'h40);
      chk("ctr2_pwm1_high", 32'(v_pwm1), 32'hFF);

      // Global enable off mid-period, then on
      tick(); tick();
      wr(NUM_CH + 1, 2);
      tick();
      chk("dis_pwm", 32'(pwm), 32'h0);
      chk("dis_pend", 32'(period_end), 32'h0);
      run(6);
      chk("dis_hold_pwm", hi[0] + hi[1], 0);
      chk("dis_hold_pend", npend, 0);
      wr(NUM_CH + 1, 3);
      centre8();
      chk("ctr3_pwm0", 32'(v_pwm0), 32'hC3);
      chk("ctr3_pend", 32'(v_pend), 32'h40);
      chk("pre_rst_pwm0", 32'(pwm[0]), 32'h1);

      // Asynchronous reset mid-period
      #2 reset = 1'b0;
      #1;
      chk("arst_pwm", 32'(pwm), 32'h0);
      chk("arst_pend", 32'(period_end), 32'h0);
      tick();
      reset = 1'b1;
      tick();
      check_all_zero("post");
      run(10);
      chk("post_no_pend", npend, 0);
      chk("post_no_pwm", hi[0] + hi[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
